// File: rtl/clock_pkg.sv
// clock_pkg: shared state/field encodings and time-field limits for the clock setting controller.
package clock_pkg;
   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;
   localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
   localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
   localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
   typedef enum logic [2:0] {IDLE, RUN, EDIT_HR, EDIT_MIN, EDIT_SEC} state_t;
   typedef enum logic [1:0] {SEL_NONE, SEL_HOUR, SEL_MIN, SEL_SEC} sel_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability debounce and rise pulse with optional auto-repeat.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int REPEAT_CYC   = 25_000_000,
   parameter bit REPEAT_EN    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic pulse_o
);
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int RW = $clog2(REPEAT_CYC + 1);
   logic          s1_q, s2_q, lvl_q, armed_q;
   logic [1:0]    warm_q;
   logic [DW-1:0] cnt_q;
   logic [RW-1:0] rep_q;
   logic          accept, rep_fire;
   assign accept   = (s2_q != lvl_q) && (cnt_q == DW'(DEBOUNCE_CYC));
   assign rep_fire = REPEAT_EN && lvl_q && (rep_q == RW'(REPEAT_CYC - 1));
   // armed only once a released level has been seen after reset, so a button held through reset is ignored
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         lvl_q   <= 1'b0;
         armed_q <= 1'b0;
         warm_q  <= 2'd0;
         cnt_q   <= '0;
         rep_q   <= '0;
         pulse_o <= 1'b0;
      end else begin
         s1_q    <= btn_i;
         s2_q    <= s1_q;
         warm_q  <= (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
         armed_q <= armed_q | (warm_q == 2'd2 && !s2_q);
         cnt_q   <= (s2_q == lvl_q || accept) ? '0 : cnt_q + DW'(1);
         lvl_q   <= lvl_q ^ accept;
         rep_q   <= (!lvl_q || rep_fire) ? '0 : rep_q + RW'(1);
         pulse_o <= armed_q && ((accept && s2_q) || rep_fire);
      end
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: three-button run/stop and time-setting controller driving a Clock block.
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int CLK_FRQ      = 100_000_000,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int REPEAT_CYC   = 25_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_mode,
   input  logic              btn_next,
   input  logic              btn_inc,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MIN_W-1:0]  cur_minute,
   input  logic [SEC_W-1:0]  cur_sec,
   output logic              start,
   output logic              stop,
   output logic              edit,
   output logic [HOUR_W-1:0] e_hour,
   output logic [MIN_W-1:0]  e_minute,
   output logic [SEC_W-1:0]  e_sec,
   output logic [1:0]        sel_field,
   output logic              blink
);
   localparam int HALF = CLK_FRQ / 2;
   localparam int BW   = $clog2(HALF + 1);
   logic          mode_p, next_p, inc_p, edit_d, inc_ok, load, bwrap;
   state_t        state_q, state_d;
   logic [BW-1:0] bcnt_q;
   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b0))
      u_mode (.clk, .rst, .btn_i(btn_mode), .pulse_o(mode_p));
   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b0))
      u_next (.clk, .rst, .btn_i(btn_next), .pulse_o(next_p));
   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1))
      u_inc (.clk, .rst, .btn_i(btn_inc), .pulse_o(inc_p));
   always_comb begin
      state_d = state_q;
      if (mode_p) state_d = (state_q == IDLE) ? RUN : IDLE;
      else if (next_p)
         state_d = (state_q == IDLE || state_q == RUN) ? EDIT_HR :
                   (state_q == EDIT_HR)  ? EDIT_MIN :
                   (state_q == EDIT_MIN) ? EDIT_SEC : IDLE;
   end
   assign edit_d = state_d inside {EDIT_HR, EDIT_MIN, EDIT_SEC};
   assign inc_ok = inc_p && !mode_p && !next_p;
   assign load   = next_p && !mode_p && (state_q == IDLE || state_q == RUN);
   assign bwrap  = bcnt_q == BW'(HALF - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q   <= IDLE;
         start     <= 1'b0;
         stop      <= 1'b0;
         edit      <= 1'b0;
         sel_field <= SEL_NONE;
         e_hour    <= '0;
         e_minute  <= '0;
         e_sec     <= '0;
         bcnt_q    <= '0;
         blink     <= 1'b0;
      end else begin
         state_q   <= state_d;
         start     <= state_q == IDLE && state_d == RUN;
         stop      <= state_q == RUN && state_d != RUN;
         edit      <= edit_d;
         sel_field <= (state_d == EDIT_HR)  ? SEL_HOUR :
                      (state_d == EDIT_MIN) ? SEL_MIN  :
                      (state_d == EDIT_SEC) ? SEL_SEC  : SEL_NONE;
         // out-of-range live values load as zero so the shadow never exceeds its limit
         if (load) begin
            e_hour   <= (cur_hour   > HOUR_MAX) ? '0 : cur_hour;
            e_minute <= (cur_minute > MIN_MAX)  ? '0 : cur_minute;
            e_sec    <= (cur_sec    > SEC_MAX)  ? '0 : cur_sec;
         end
         if (inc_ok && state_q == EDIT_HR)  e_hour   <= (e_hour   >= HOUR_MAX) ? '0 : e_hour + HOUR_W'(1);
         if (inc_ok && state_q == EDIT_MIN) e_minute <= (e_minute >= MIN_MAX)  ? '0 : e_minute + MIN_W'(1);
         if (inc_ok && state_q == EDIT_SEC) e_sec    <= (e_sec    >= SEC_MAX)  ? '0 : e_sec + SEC_W'(1);
         bcnt_q    <= (!edit_d || state_d != state_q || bwrap) ? '0 : bcnt_q + BW'(1);
         blink     <= edit_d && state_d == state_q && (blink ^ bwrap);
      end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed stimulus checked every cycle against a sample-history behavioural model.
module tb_clock_set_ctrl;
   localparam int FRQ = 10, DEB = 4, REP = 20, HALF = FRQ / 2;
   localparam int S_IDLE = 0, S_RUN = 1, S_EHR = 2, S_ESEC = 4;
   logic clk = 1'b0, rst = 1'b0;
   logic btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0;
   logic [4:0] cur_hour = 5'd12;
   logic [5:0] cur_minute = 6'd59, cur_sec = 6'd55;
   logic start, stop, edit, blink;
   logic [4:0] e_hour;
   logic [5:0] e_minute, e_sec;
   logic [1:0] sel_field;
   int total = 0, bad = 0, n_start = 0, n_stop = 0;
   bit chk_on = 0;
   clock_set_ctrl #(.CLK_FRQ(FRQ), .DEBOUNCE_CYC(DEB), .REPEAT_CYC(REP)) dut (
      .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
      .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_sec(cur_sec),
      .start(start), .stop(stop), .edit(edit), .e_hour(e_hour), .e_minute(e_minute),
      .e_sec(e_sec), .sel_field(sel_field), .blink(blink));
   always #5 clk = ~clk;
   wire [22:0] act = {start, stop, edit, sel_field, blink, e_hour, e_minute, e_sec};
   // model: raw samples per edge since reset release; a level is accepted once DEB+1 samples, two edges old, agree
   bit hist [3][4096];
   int ec = 0, mst = 0, t = 0;
   int val [3] = '{0, 0, 0};
   int lim [3] = '{24, 60, 60};
   int acc_k [3] = '{0, 0, 0};
   int first0 [3] = '{1 << 30, 1 << 30, 1 << 30};
   bit acc [3] = '{0, 0, 0};
   bit pend [3] = '{0, 0, 0};
   bit mstart = 0, mstop = 0;
   function automatic bit btn_event(int b, int k);
      bit fire = 0, stable = 1, v;
      if (b == 2 && acc[b] && k > acc_k[b] && (k - acc_k[b]) % REP == 0) fire = 1;
      if (k - DEB - 2 >= 1 && k < 4096) begin
         v = hist[b][k-2];
         for (int j = k - DEB - 2; j <= k - 2; j++) if (hist[b][j] != v) stable = 0;
         if (stable && v != acc[b]) begin
            acc[b] = v;
            acc_k[b] = k;
            if (v) fire = 1;
         end
      end
      return fire && first0[b] <= k - 3;
   endfunction
   task automatic fsm_step(bit mp, bit np, bit ip);
      bit chg = 0;
      mstart = 0;
      mstop = 0;
      if (mp) begin
         mstart = (mst == S_IDLE);
         mstop = (mst == S_RUN);
         mst = (mst == S_IDLE) ? S_RUN : S_IDLE;
         chg = 1;
      end else if (np) begin
         if (mst <= S_RUN) begin
            mstop = (mst == S_RUN);
            val[0] = cur_hour > 23 ? 0 : int'(cur_hour);
            val[1] = cur_minute > 59 ? 0 : int'(cur_minute);
            val[2] = cur_sec > 59 ? 0 : int'(cur_sec);
            mst = S_EHR;
         end else mst = (mst == S_ESEC) ? S_IDLE : mst + 1;
         chg = 1;
      end else if (ip && mst >= S_EHR) val[mst-S_EHR] = (val[mst-S_EHR] + 1) % lim[mst-S_EHR];
      t = chg ? 0 : t + 1;
   endtask
   function automatic logic [31:0] model_out();
      bit ed = mst >= S_EHR;
      logic [1:0] sl = ed ? 2'(mst - 1) : 2'd0;
      bit bl = ed && ((t / HALF) % 2 == 1);
      return 32'({mstart, mstop, ed, sl, bl, 5'(val[0]), 6'(val[1]), 6'(val[2])});
   endfunction
   always @(posedge clk or posedge rst)
      if (rst) begin
         ec = 0; mst = S_IDLE; t = 0; mstart = 0; mstop = 0;
         for (int b = 0; b < 3; b++) begin
            val[b] = 0; acc[b] = 0; acc_k[b] = 0; first0[b] = 1 << 30; pend[b] = 0;
         end
      end else begin
         ec++;
         if (ec < 4096) begin
            hist[0][ec] = btn_mode;
            hist[1][ec] = btn_next;
            hist[2][ec] = btn_inc;
            for (int b = 0; b < 3; b++) if (!hist[b][ec] && first0[b] > ec) first0[b] = ec;
         end
         fsm_step(pend[0], pend[1], pend[2]);
         for (int b = 0; b < 3; b++) pend[b] = btn_event(b, ec);
      end
   task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
      end
   endtask
   always @(negedge clk)
      if (chk_on) begin
         check("outputs_vs_model", 32'(act), model_out());
         if (start === 1'b1) n_start++;
         if (stop === 1'b1) n_stop++;
      end
   task automatic set_btn(input int b, input logic v);
      if (b == 0) btn_mode = v;
      else if (b == 1) btn_next = v;
      else btn_inc = v;
   endtask
   task automatic press(input int b, input int hold);
      set_btn(b, 1'b1);
      repeat (hold) @(negedge clk);
      set_btn(b, 1'b0);
      repeat (DEB + 12) @(negedge clk);
   endtask
   initial begin
      #1 rst = 1'b1;
      #2 chk_on = 1;
      check("reset_zero", 32'(act), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      press(0, 10);
      check("start_count", n_start, 1);
      check("run_no_edit", 32'(edit), 32'd0);
      press(0, 10);
      check("stop_count", n_stop, 1);
      press(1, 8);
      check("hr_sel", 32'(sel_field), 32'd1);
      check("hr_load", 32'({e_hour, e_minute, e_sec}), 32'({5'd12, 6'd59, 6'd55}));
      repeat (3) press(2, 8);
      check("hr_inc3", 32'(e_hour), 32'd15);
      press(1, 8);
      check("min_sel", 32'(sel_field), 32'd2);
      press(2, 8);
      check("min_wrap", 32'({e_hour, e_minute, e_sec}), 32'({5'd15, 6'd0, 6'd55}));
      press(1, 8);
      check("sec_sel", 32'({edit, sel_field}), 32'({1'b1, 2'd3}));
      press(1, 8);
      check("exit_idle", 32'({edit, sel_field}), 32'd0);
      check("final_time", 32'({e_hour, e_minute, e_sec}), 32'({5'd15, 6'd0, 6'd55}));
      cur_hour = 5'd23; cur_minute = 6'd59; cur_sec = 6'd10;
      press(1, 8);
      press(2, 8);
      check("hr_23_wrap", 32'({e_hour, e_minute, e_sec}), 32'({5'd0, 6'd59, 6'd10}));
      press(1, 8);
      press(2, 8);
      check("min_59_wrap", 32'({e_hour, e_minute, e_sec}), 32'({5'd0, 6'd0, 6'd10}));
      press(1, 8);
      press(2, 2);
      check("glitch_ignored", 32'(e_sec), 32'd10);
      press(2, 50);
      check("inc_repeat", 32'(e_sec), 32'd13);
      press(0, 8);
      check("mode_abort", 32'({edit, e_hour, e_minute, e_sec}), 32'({1'b0, 5'd0, 6'd0, 6'd13}));
      check("no_stop_from_edit", n_stop, 1);
      btn_mode = 1'b1; btn_next = 1'b1;
      repeat (8) @(negedge clk);
      btn_mode = 1'b0; btn_next = 1'b0;
      repeat (DEB + 12) @(negedge clk);
      check("mode_over_next", n_start, 2);
      check("no_edit_entry", 32'({edit, sel_field}), 32'd0);
      press(0, 8);
      check("stop_count2", n_stop, 2);
      cur_hour = 5'd31; cur_minute = 6'd63; cur_sec = 6'd60;
      press(1, 8);
      check("clamp_load", 32'({e_hour, e_minute, e_sec}), 32'd0);
      press(2, 8);
      press(1, 8);
      press(2, 8);
      check("pre_reset", 32'({sel_field, e_hour, e_minute}), 32'({2'd2, 5'd1, 6'd1}));
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check("rst_mid_edit", 32'(act), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("no_pulse_on_release", n_start + n_stop, 4);
      rst = 1'b1;
      btn_mode = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("held_through_reset", n_start, 2);
      btn_mode = 1'b0;
      repeat (DEB + 12) @(negedge clk);
      press(0, 8);
      check("press_after_release", n_start, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
